// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared checker state encoding and the XNOR Fibonacci LFSR step (taps for widths 3..32)
package lfsr_pkg;
  typedef enum logic [1:0] {SEARCH = 2'b00, VERIFY = 2'b01, LOCKED = 2'b10} chk_state_t;
  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input int n);
    logic [31:0] t;
    logic [31:0] m;
    case (n)
      3: t = 32'h0000_0006;
      4: t = 32'h0000_000C;
      5: t = 32'h0000_0014;
      6: t = 32'h0000_0030;
      7: t = 32'h0000_0060;
      8: t = 32'h0000_00B8;
      9: t = 32'h0000_0110;
      10: t = 32'h0000_0240;
      11: t = 32'h0000_0500;
      12: t = 32'h0000_0829;
      13: t = 32'h0000_100D;
      14: t = 32'h0000_2015;
      15: t = 32'h0000_6000;
      16: t = 32'h0000_D008;
      17: t = 32'h0001_2000;
      18: t = 32'h0002_0400;
      19: t = 32'h0004_0023;
      20: t = 32'h0009_0000;
      21: t = 32'h0014_0000;
      22: t = 32'h0030_0000;
      23: t = 32'h0042_0000;
      24: t = 32'h00E1_0000;
      25: t = 32'h0120_0000;
      26: t = 32'h0200_0023;
      27: t = 32'h0400_0013;
      28: t = 32'h0900_0000;
      29: t = 32'h1400_0000;
      30: t = 32'h2000_0029;
      31: t = 32'h4800_0000;
      32: t = 32'h8020_0003;
      default: t = 32'h0;
    endcase
    m = (n >= 32) ? 32'hFFFF_FFFF : (32'd1 << n) - 32'd1;
    return ((s << 1) | {31'b0, ~^(s & t)}) & m;
  endfunction
endpackage

// File: rtl/lfsr_chk_popcount.sv
// lfsr_chk_popcount: combinational population count (i_Bits -> o_Count)
module lfsr_chk_popcount #(
  parameter int NUM_BITS = 8
) (
  input  logic [NUM_BITS-1:0]           i_Bits,
  output logic [$clog2(NUM_BITS+1)-1:0] o_Count
);
  localparam int W = $clog2(NUM_BITS + 1);
  always_comb begin
    o_Count = '0;
    for (int i = 0; i < NUM_BITS; i++) o_Count = o_Count + W'(i_Bits[i]);
  end
endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising XNOR-LFSR PRBS checker (in: i_Clk i_Rst_n i_Enable i_Valid i_Data i_Clear_Counts; out: o_Locked o_Err o_Err_Count o_Word_Count o_State; LFSR_CHECKER_BIT_ERR_EN adds o_Bit_Err_Count)
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS    = 8,
  parameter int LOCK_COUNT  = 16,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_W       = 32
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                i_Enable,
  input  logic                i_Valid,
  input  logic [NUM_BITS-1:0] i_Data,
  input  logic                i_Clear_Counts,
  output logic                o_Locked,
  output logic                o_Err,
  output logic [CNT_W-1:0]    o_Err_Count,
  output logic [CNT_W-1:0]    o_Word_Count,
  output logic [1:0]          o_State
`ifdef LFSR_CHECKER_BIT_ERR_EN
  ,output logic [CNT_W-1:0]   o_Bit_Err_Count
`endif
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_THRESH + 1);
  chk_state_t state;
  logic [NUM_BITS-1:0] pred, word_nxt, pred_nxt;
  logic [MW-1:0] match_cnt;
  logic [LW-1:0] miss_cnt;
  logic accept, all_ones, hit, locked_acc, err_ev;
  logic [CNT_W-1:0] wc_d, ec_d;
  assign accept = i_Enable & i_Valid;
  assign all_ones = &i_Data;
  assign hit = i_Data == pred;
  assign word_nxt = NUM_BITS'(lfsr_next(32'(i_Data), NUM_BITS));
  assign pred_nxt = NUM_BITS'(lfsr_next(32'(pred), NUM_BITS));
  assign locked_acc = accept && state == LOCKED;
  assign err_ev = locked_acc && !hit;
  assign wc_d = i_Clear_Counts ? '0 : (locked_acc && !(&o_Word_Count)) ? o_Word_Count + CNT_W'(1) : o_Word_Count;
  assign ec_d = i_Clear_Counts ? '0 : (err_ev && !(&o_Err_Count)) ? o_Err_Count + CNT_W'(1) : o_Err_Count;
  assign o_State = state;
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= SEARCH;
      pred <= '0;
      match_cnt <= '0;
      miss_cnt <= '0;
      o_Locked <= 1'b0;
      o_Err <= 1'b0;
      o_Err_Count <= '0;
      o_Word_Count <= '0;
    end else begin
      o_Err <= err_ev;
      o_Err_Count <= ec_d;
      o_Word_Count <= wc_d;
      if (accept) begin
        case (state)
          SEARCH: if (!all_ones) begin
            pred <= word_nxt;
            match_cnt <= '0;
            state <= VERIFY;
          end
          VERIFY: if (hit) begin
            pred <= word_nxt;
            if (match_cnt == MW'(LOCK_COUNT - 1)) begin
              state <= LOCKED;
              o_Locked <= 1'b1;
              miss_cnt <= '0;
            end else match_cnt <= match_cnt + MW'(1);
          end else if (all_ones) state <= SEARCH;
          else begin
            pred <= word_nxt;
            match_cnt <= '0;
          end
          LOCKED: begin
            // free-running prediction keeps corrupted words out of the reference
            pred <= pred_nxt;
            if (hit) miss_cnt <= '0;
            else if (miss_cnt == LW'(LOSS_THRESH - 1)) begin
              state <= SEARCH;
              o_Locked <= 1'b0;
              miss_cnt <= '0;
            end else miss_cnt <= miss_cnt + LW'(1);
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end
`ifdef LFSR_CHECKER_BIT_ERR_EN
  localparam int PW = $clog2(NUM_BITS + 1);
  logic [PW-1:0] pc;
  logic [CNT_W:0] bsum;
  lfsr_chk_popcount #(.NUM_BITS(NUM_BITS)) u_pop (.i_Bits(i_Data ^ pred), .o_Count(pc));
  assign bsum = {1'b0, o_Bit_Err_Count} + (CNT_W + 1)'(pc);
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) o_Bit_Err_Count <= '0;
    else o_Bit_Err_Count <= i_Clear_Counts ? '0 : !locked_acc ? o_Bit_Err_Count : bsum[CNT_W] ? '1 : bsum[CNT_W-1:0];
  end
`endif
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: scoreboard bench for lfsr_checker with directed PRBS streams and hand-computed checkpoints
module tb_lfsr_checker;
  import lfsr_pkg::*;
  localparam int CMAX = 31;
  logic i_Clk = 1'b0, i_Rst_n = 1'b0, i_Enable = 1'b1, i_Valid = 1'b0, i_Clear_Counts = 1'b0;
  logic [7:0] i_Data = 8'h00;
  logic o_Locked, o_Err;
  logic [4:0] o_Err_Count, o_Word_Count;
  logic [1:0] o_State;
`ifdef LFSR_CHECKER_BIT_ERR_EN
  logic [4:0] o_Bit_Err_Count;
`endif
  lfsr_checker #(.NUM_BITS(8), .LOCK_COUNT(16), .LOSS_THRESH(8), .CNT_W(5)) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Enable(i_Enable), .i_Valid(i_Valid), .i_Data(i_Data),
    .i_Clear_Counts(i_Clear_Counts), .o_Locked(o_Locked), .o_Err(o_Err), .o_Err_Count(o_Err_Count),
    .o_Word_Count(o_Word_Count), .o_State(o_State)
`ifdef LFSR_CHECKER_BIT_ERR_EN
    , .o_Bit_Err_Count(o_Bit_Err_Count)
`endif
  );
  always #5 i_Clk = ~i_Clk;
  typedef struct {logic [1:0] st; logic lk; logic er; logic [4:0] ec; logic [4:0] wc; logic [4:0] bec;} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  int m_st = 0, m_match = 0, m_miss = 0, m_ec = 0, m_wc = 0, m_bec = 0;
  logic [7:0] m_pred = 8'h00;
  logic m_err = 1'b0;
  logic [7:0] g = 8'h01;
  localparam logic [7:0] SEQ [10] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3D, 8'h7A, 8'hF4, 8'hE8, 8'hD0};
  function automatic logic [7:0] nx(input logic [7:0] s);
    return 8'(lfsr_next({24'b0, s}, 8));
  endfunction
  function automatic int sat(input int x);
    return x > CMAX ? CMAX : x;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] b);
    checks++;
    if (a !== b) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, b);
    end
  endtask
  task automatic model_step();
    int pc;
    m_err = 1'b0;
    if (i_Enable && i_Valid) begin
      if (m_st == 0) begin
        if (i_Data != 8'hFF) begin
          m_pred = nx(i_Data);
          m_match = 0;
          m_st = 1;
        end
      end else if (m_st == 1) begin
        if (i_Data == m_pred) begin
          m_pred = nx(i_Data);
          m_match++;
          if (m_match == 16) begin
            m_st = 2;
            m_miss = 0;
          end
        end else if (i_Data == 8'hFF) m_st = 0;
        else begin
          m_pred = nx(i_Data);
          m_match = 0;
        end
      end else begin
        m_wc = sat(m_wc + 1);
        pc = $countones(i_Data ^ m_pred);
        if (pc != 0) begin
          m_err = 1'b1;
          m_ec = sat(m_ec + 1);
          m_bec = sat(m_bec + pc);
          m_miss++;
          if (m_miss == 8) m_st = 0;
        end else m_miss = 0;
        m_pred = nx(m_pred);
      end
    end
    if (i_Clear_Counts) begin
      m_ec = 0;
      m_wc = 0;
      m_bec = 0;
    end
  endtask
  task automatic cyc(input logic v, input logic [7:0] d, input logic c = 1'b0, input logic e = 1'b1);
    i_Valid = v;
    i_Data = d;
    i_Clear_Counts = c;
    i_Enable = e;
    @(posedge i_Clk);
    #1;
    model_step();
    q.push_back('{st: 2'(m_st), lk: m_st == 2, er: m_err, ec: 5'(m_ec), wc: 5'(m_wc), bec: 5'(m_bec)});
  endtask
  task automatic gword(input logic [7:0] f = 8'h00, input logic c = 1'b0);
    cyc(1'b1, g ^ f, c, 1'b1);
    g = nx(g);
  endtask
  always @(negedge i_Clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sb_state", 32'(o_State), 32'(e.st));
      chk("sb_locked", 32'(o_Locked), 32'(e.lk));
      chk("sb_err", 32'(o_Err), 32'(e.er));
      chk("sb_err_count", 32'(o_Err_Count), 32'(e.ec));
      chk("sb_word_count", 32'(o_Word_Count), 32'(e.wc));
`ifdef LFSR_CHECKER_BIT_ERR_EN
      chk("sb_bit_err_count", 32'(o_Bit_Err_Count), 32'(e.bec));
`endif
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
  initial begin
    logic [7:0] s;
    s = 8'h01;
    for (int i = 0; i < 10; i++) begin
      chk("gen_seq", 32'(s), 32'(SEQ[i]));
      s = nx(s);
    end
    repeat (2) @(posedge i_Clk);
    #1;
    chk("rst_state", 32'(o_State), 0);
    chk("rst_locked", 32'(o_Locked), 0);
    chk("rst_err", 32'(o_Err), 0);
    chk("rst_err_count", 32'(o_Err_Count), 0);
    chk("rst_word_count", 32'(o_Word_Count), 0);
    @(negedge i_Clk);
    i_Rst_n = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      gword();
      if (i == 1) chk("t1_verify_after_1", 32'(o_State), 1);
      if (i == 16) chk("t1_unlocked_16", 32'(o_Locked), 0);
      if (i == 17) chk("t1_locked_17", 32'(o_Locked), 1);
    end
    chk("t1_err_count", 32'(o_Err_Count), 0);
    chk("t1_word_count", 32'(o_Word_Count), 23);
    gword(8'h08);
    chk("t2_err_pulse", 32'(o_Err), 1);
    chk("t2_err_count", 32'(o_Err_Count), 1);
    chk("t2_locked", 32'(o_Locked), 1);
`ifdef LFSR_CHECKER_BIT_ERR_EN
    chk("t2_bit_err_count", 32'(o_Bit_Err_Count), 1);
`endif
    gword();
    chk("t2_next_clean", 32'(o_Err), 0);
    chk("t2_err_count_hold", 32'(o_Err_Count), 1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t3_clear_wc", 32'(o_Word_Count), 0);
    chk("t3_clear_locked", 32'(o_Locked), 1);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 8'h00);
      g = nx(g);
      if (i == 7) chk("t3_locked_7", 32'(o_Locked), 1);
    end
    chk("t3_err_count", 32'(o_Err_Count), 8);
    chk("t3_word_count", 32'(o_Word_Count), 8);
    chk("t3_unlocked", 32'(o_Locked), 0);
    chk("t3_search", 32'(o_State), 0);
    repeat (4) cyc(1'b1, 8'hFF);
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("t4_search_held", 32'(o_State), 0);
    chk("t4_err_count_held", 32'(o_Err_Count), 8);
    for (int i = 1; i <= 17; i++) begin
      cyc(1'b0, 8'h5A);
      gword();
      if (i == 16) chk("t4_unlocked_16", 32'(o_Locked), 0);
      if (i == 17) chk("t4_locked_17", 32'(o_Locked), 1);
    end
    gword(8'h08, 1'b1);
    chk("t5_err_pulse", 32'(o_Err), 1);
    chk("t5_err_count", 32'(o_Err_Count), 0);
    chk("t5_word_count", 32'(o_Word_Count), 0);
    repeat (3) gword();
    chk("t6_pre_wc", 32'(o_Word_Count), 3);
    @(negedge i_Clk);
    #2 i_Rst_n = 1'b0;
    #1;
    chk("t6_async_state", 32'(o_State), 0);
    chk("t6_async_locked", 32'(o_Locked), 0);
    chk("t6_async_wc", 32'(o_Word_Count), 0);
    chk("t6_async_err", 32'(o_Err), 0);
    {m_st, m_match, m_miss, m_ec, m_wc, m_bec} = '0;
    m_pred = 8'h00;
    m_err = 1'b0;
    repeat (2) @(posedge i_Clk);
    @(negedge i_Clk);
    i_Rst_n = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      gword();
      if (i == 16) chk("t6_unlocked_16", 32'(o_Locked), 0);
      if (i == 17) chk("t6_locked_17", 32'(o_Locked), 1);
    end
    repeat (40) gword();
    chk("sat_word_count", 32'(o_Word_Count), 31);
    repeat (35) begin
      gword(8'h08);
      gword();
    end
    chk("sat_err_count", 32'(o_Err_Count), 31);
    chk("sat_locked", 32'(o_Locked), 1);
`ifdef LFSR_CHECKER_BIT_ERR_EN
    chk("sat_bit_err_count", 32'(o_Bit_Err_Count), 31);
`endif
    i_Valid = 1'b0;
    @(negedge i_Clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
